std_divmod_pipe: RTL
====================

STD_DIVMOD_PIPE -- requirements
Module: std_divmod_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width in bits; legal range 2..64.
REQ-002 SHALL have parameter SIGNED, default 0: 0 = unsigned operands, 1 = two's-complement operands.
REQ-003 SHALL have parameter FLOOR, default 0: 0 = truncated division, 1 = floored division; ignored when SIGNED=0.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-006 SHALL have port go, input, 1 bit: level request; held high until done is observed.
REQ-007 SHALL have port left, input, WIDTH bits: dividend.
REQ-008 SHALL have port right, input, WIDTH bits: divisor.
REQ-009 SHALL have port quotient, output, WIDTH bits: registered quotient.
REQ-010 SHALL have port remainder, output, WIDTH bits: registered remainder.
REQ-011 SHALL have port div_by_zero, output, 1 bit: registered flag; 1 when the last result had right == 0.
REQ-012 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, FIN, WAIT.
REQ-014 In IDLE, go=1 at edge k SHALL capture left/right, convert them to magnitudes if SIGNED=1, record the sign information, clear the iteration counter, and enter BUSY.
REQ-015 BUSY SHALL perform one restoring shift-subtract step per edge, MSB first, for exactly WIDTH edges (k+1..k+WIDTH), then enter FIN.
REQ-016 FIN SHALL apply sign and floor correction, register the results, and drive done=1 during the cycle after edge k+WIDTH+1; total latency is WIDTH+2 edges including capture.
REQ-017 Fast path: right == 0 or left == 0 at capture SHALL skip BUSY; done=1 during the cycle after edge k+1.
REQ-018 After done, the FSM SHALL enter WAIT; done SHALL be 1 for exactly one cycle.
REQ-019 WAIT SHALL return to IDLE only when go is sampled 0; go held high after done SHALL NOT start a new operation.
REQ-020 go=0 sampled in BUSY or FIN SHALL abort to IDLE with no done pulse; outputs SHALL keep their previous values.
REQ-021 quotient, remainder and div_by_zero SHALL hold their values from done until the next FIN or fast-path completion.
REQ-022 Unsigned mode: quotient = floor(left/right); remainder = left mod right.
REQ-023 Signed truncated mode (FLOOR=0): quotient rounds toward zero; remainder takes the sign of left; left == quotient*right + remainder.
REQ-024 Signed floored mode (FLOOR=1): if the truncated remainder is nonzero and its sign differs from the sign of right, the block SHALL output quotient-1 and remainder+right.
REQ-025 Divide by zero SHALL give quotient all-ones, remainder = left, and div_by_zero = 1, in all modes.
REQ-026 Signed overflow (left = most negative value, right = -1) SHALL give quotient = left, remainder = 0, and div_by_zero = 0.
REQ-027 Operand changes after the capture edge SHALL NOT affect the result.
REQ-028 Internal datapath width SHALL be WIDTH+1 bits for the partial remainder; magnitude of the most negative value SHALL be handled without overflow.

Reset
REQ-029 reset=0 at any rising edge SHALL force IDLE and set quotient=0, remainder=0, div_by_zero=0, done=0, regardless of go or the current state.
REQ-030 reset asserted mid-operation SHALL discard the operation; no done pulse SHALL follow the release of reset unless go is sampled in IDLE.

Verification (WIDTH=8)
REQ-031 SIGNED=0, left=200, right=7, go held -> done in the cycle after edge 9 counted from capture (edge 0); quotient=28, remainder=4, div_by_zero=0.
REQ-032 SIGNED=1, FLOOR=0, left=-7 (0xF9), right=2 -> quotient=0xFD (-3), remainder=0xFF (-1); with FLOOR=1 -> quotient=0xFC (-4), remainder=0x01.
REQ-033 SIGNED=1, left=5, right=0 -> done after edge 1; quotient=0xFF, remainder=5, div_by_zero=1; then left=-128, right=-1 -> quotient=0x80, remainder=0, div_by_zero=0.
REQ-034 left=100, right=10, go dropped at edge 4 -> no done pulse, returns to IDLE; go reasserted -> quotient=10, remainder=0 after the full latency.
REQ-035 go held high for 5 cycles after done -> no second done pulse; go low for 1 cycle then high -> a new operation starts.
REQ-036 reset=0 at edge 3 of an operation -> all outputs 0 at the next cycle; done never asserts for the aborted operation.

Source files
------------

// File: rtl/std_divmod_pipe.sv
// Iterative restoring divider with quotient/remainder, optional signed operands
// and floored rounding. One quotient bit per clock, go/done level handshake.
module std_divmod_pipe #(
   parameter int WIDTH  = 32,
   parameter bit SIGNED = 1'b0,
   parameter bit FLOOR  = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   input  logic [WIDTH-1:0] left,
   input  logic [WIDTH-1:0] right,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             done
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, BUSY, FIN, WAIT} state_t;

   state_t           state, state_next;
   logic [CW-1:0]    count;
   logic [WIDTH:0]   part_rem;
   logic [WIDTH-1:0] quo_sh;
   logic [WIDTH-1:0] divisor_mag;
   logic [WIDTH-1:0] left_reg;
   logic [WIDTH-1:0] right_reg;
   logic             neg_quo;
   logic             neg_rem;
   logic             zero_div;

   logic             left_neg, right_neg, fast;
   logic [WIDTH-1:0] left_mag, right_mag;
   logic [WIDTH:0]   shifted, trial;
   logic [WIDTH-1:0] q_trunc, r_trunc, q_final, r_final;
   logic             fix;
   logic             last_step;

   // Magnitudes stay WIDTH bits unsigned, so the most negative value maps cleanly.
   always_comb begin
      left_neg  = SIGNED && left[WIDTH-1];
      right_neg = SIGNED && right[WIDTH-1];
      left_mag  = left_neg  ? -left  : left;
      right_mag = right_neg ? -right : right;
      fast      = (right == '0) || (left == '0);
      last_step = (count == CW'(WIDTH - 1));
   end

   always_comb begin
      shifted = {part_rem[WIDTH-1:0], quo_sh[WIDTH-1]};
      trial   = shifted - {1'b0, divisor_mag};
   end

   // Sign restoration, then floored adjustment when the remainder disagrees with the divisor.
   always_comb begin
      q_trunc = neg_quo ? -quo_sh : quo_sh;
      r_trunc = neg_rem ? -part_rem[WIDTH-1:0] : part_rem[WIDTH-1:0];
      fix     = FLOOR && SIGNED && (r_trunc != '0) && (r_trunc[WIDTH-1] != right_reg[WIDTH-1]);
      q_final = q_trunc;
      r_final = r_trunc;
      if (zero_div) begin
         q_final = '1;
         r_final = left_reg;
      end else if (fix) begin
         q_final = q_trunc - WIDTH'(1);
         r_final = r_trunc + right_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (go) state_next = fast ? FIN : BUSY;
         BUSY: begin
            if (!go)            state_next = IDLE;
            else if (last_step) state_next = FIN;
         end
         FIN:  state_next = go ? WAIT : IDLE;
         WAIT: if (!go) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count       <= '0;
         part_rem    <= '0;
         quo_sh      <= '0;
         divisor_mag <= '0;
         left_reg    <= '0;
         right_reg   <= '0;
         neg_quo     <= 1'b0;
         neg_rem     <= 1'b0;
         zero_div    <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (go) begin
                  count       <= '0;
                  part_rem    <= '0;
                  quo_sh      <= left_mag;
                  divisor_mag <= right_mag;
                  left_reg    <= left;
                  right_reg   <= right;
                  neg_quo     <= left_neg ^ right_neg;
                  neg_rem     <= left_neg;
                  zero_div    <= (right == '0);
               end
            end
            BUSY: begin
               count <= count + CW'(1);
               if (!trial[WIDTH]) begin
                  part_rem <= trial;
                  quo_sh   <= {quo_sh[WIDTH-2:0], 1'b1};
               end else begin
                  part_rem <= shifted;
                  quo_sh   <= {quo_sh[WIDTH-2:0], 1'b0};
               end
            end
            FIN: begin
               if (go) begin
                  quotient    <= q_final;
                  remainder   <= r_final;
                  div_by_zero <= zero_div;
                  done        <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
